// File: rtl/ring_seq_ctrl_if.sv
// Host command port for ring_seq_ctrl: one command per valid/ready transfer.
// A command transfers on a rising edge where cmd_valid && cmd_ready; the master
// holds op/data stable while valid is high, and the slave never stalls outside reset.
interface ring_seq_ctrl_if #(
    parameter int CNT_W = 24
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/ring_seq_ctrl.sv
// LED ring sequencer: tick divider, pattern register, direction and run/stop
// control, programmed through ring_seq_ctrl_if.
module ring_seq_ctrl #(
    parameter int WIDTH          = 16,
    parameter int CNT_W          = 24,
    parameter int DEFAULT_PERIOD = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    ring_seq_ctrl_if.slave   cmd,
    output logic [WIDTH-1:0] out,
    output logic             running,
    output logic             step,
    output logic             done
);
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [2:0] OP_SET_PERIOD = 3'd0;
    localparam logic [2:0] OP_LOAD       = 3'd1;
    localparam logic [2:0] OP_SET_MODE   = 3'd2;
    localparam logic [2:0] OP_START      = 3'd3;
    localparam logic [2:0] OP_STOP       = 3'd4;
    localparam logic       DIR_LEFT      = 1'b0;
    localparam logic       DIR_RIGHT     = 1'b1;
    localparam logic [CNT_W-1:0] C_DEFAULT_PERIOD = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] C_ONE            = CNT_W'(1);

    state_t           r_state, w_state_n;
    logic [WIDTH-1:0] r_out, w_out_n;
    logic [CNT_W-1:0] r_period, w_period_n;
    logic [CNT_W-1:0] r_cntr, w_cntr_n;
    logic [CNT_W-1:0] r_remaining, w_remaining_n;
    logic [1:0]       r_mode, w_mode_n;
    logic             r_dir, w_dir_n;
    logic             r_step, w_step_n;
    logic             r_done, w_done_n;

    logic             w_xfer;
    logic             w_tick;
    logic [WIDTH-1:0] w_rol, w_ror, w_shift;
    logic             w_dir_shift;

    assign cmd.cmd_ready = ~rst;
    assign w_xfer        = cmd.cmd_valid & ~rst;
    assign w_tick        = (r_state == ST_RUN) && (r_cntr == '0);
    assign w_rol         = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
    assign w_ror         = {r_out[0], r_out[WIDTH-1:1]};

    // Pattern after one step under the current mode; bounce turns at either end.
    always_comb begin
        w_shift     = r_out;
        w_dir_shift = r_dir;
        case (r_mode)
            2'd0: w_shift = w_rol;
            2'd1: w_shift = w_ror;
            2'd2: begin
                if (r_dir == DIR_LEFT && r_out[WIDTH-1]) begin
                    w_shift     = w_ror;
                    w_dir_shift = DIR_RIGHT;
                end else if (r_dir == DIR_RIGHT && r_out[0]) begin
                    w_shift     = w_rol;
                    w_dir_shift = DIR_LEFT;
                end else begin
                    w_shift = (r_dir == DIR_LEFT) ? w_rol : w_ror;
                end
            end
            default: w_shift = r_out;
        endcase
    end

    always_comb begin
        w_state_n     = r_state;
        w_out_n       = r_out;
        w_period_n    = r_period;
        w_cntr_n      = r_cntr;
        w_remaining_n = r_remaining;
        w_mode_n      = r_mode;
        w_dir_n       = r_dir;
        w_step_n      = 1'b0;
        w_done_n      = 1'b0;

        if (w_tick) begin
            w_cntr_n = r_period - C_ONE;
            w_out_n  = w_shift;
            w_dir_n  = w_dir_shift;
            w_step_n = 1'b1;
            if (r_remaining != '0) begin
                w_remaining_n = r_remaining - C_ONE;
                if (r_remaining == C_ONE) begin
                    w_state_n = ST_IDLE;
                    w_done_n  = 1'b1;
                end
            end
        end else if (r_state == ST_RUN) begin
            w_cntr_n = r_cntr - C_ONE;
        end

        // A same-edge command overrides the tick's effects where they conflict.
        if (w_xfer) begin
            case (cmd.cmd_op)
                OP_SET_PERIOD: w_period_n = (cmd.cmd_data == '0) ? C_ONE : cmd.cmd_data;
                OP_LOAD: begin
                    w_out_n       = cmd.cmd_data[WIDTH-1:0];
                    w_dir_n       = r_dir;
                    w_state_n     = r_state;
                    w_remaining_n = r_remaining;
                    w_step_n      = 1'b0;
                    w_done_n      = 1'b0;
                    if (r_state == ST_RUN) w_cntr_n = r_period - C_ONE;
                end
                OP_SET_MODE: begin
                    w_mode_n = cmd.cmd_data[1:0];
                    w_dir_n  = (cmd.cmd_data[1:0] == 2'd1) ? DIR_RIGHT : DIR_LEFT;
                end
                OP_START: begin
                    w_state_n     = ST_RUN;
                    w_cntr_n      = r_period - C_ONE;
                    w_remaining_n = cmd.cmd_data;
                    w_out_n       = r_out;
                    w_dir_n       = r_dir;
                    w_step_n      = 1'b0;
                    w_done_n      = 1'b0;
                end
                OP_STOP: begin
                    w_state_n     = ST_IDLE;
                    w_out_n       = r_out;
                    w_dir_n       = r_dir;
                    w_cntr_n      = r_cntr;
                    w_remaining_n = r_remaining;
                    w_step_n      = 1'b0;
                    w_done_n      = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out       <= WIDTH'(1);
            r_period    <= C_DEFAULT_PERIOD;
            r_cntr      <= '0;
            r_remaining <= '0;
            r_mode      <= 2'd0;
            r_dir       <= DIR_LEFT;
            r_step      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_out       <= w_out_n;
            r_period    <= w_period_n;
            r_cntr      <= w_cntr_n;
            r_remaining <= w_remaining_n;
            r_mode      <= w_mode_n;
            r_dir       <= w_dir_n;
            r_step      <= w_step_n;
            r_done      <= w_done_n;
        end
    end

    assign out     = r_out;
    assign running = (r_state == ST_RUN);
    assign step    = r_step;
    assign done    = r_done;
endmodule

// File: tb/tb_ring_seq_ctrl.sv
// Directed bench for ring_seq_ctrl: period, modes, finite runs, collisions, reset.
module tb_ring_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int CNT_W = 24;
    localparam int DEF_P = 20;

    localparam logic [2:0] OP_SET_PERIOD = 3'd0;
    localparam logic [2:0] OP_LOAD       = 3'd1;
    localparam logic [2:0] OP_SET_MODE   = 3'd2;
    localparam logic [2:0] OP_START      = 3'd3;
    localparam logic [2:0] OP_STOP       = 3'd4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] out;
    logic             running;
    logic             step;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    ring_seq_ctrl_if #(.CNT_W(CNT_W)) cmd_if ();

    ring_seq_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .DEFAULT_PERIOD(DEF_P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd(cmd_if),
        .out(out),
        .running(running),
        .step(step),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one command for exactly one edge; returns 1ns after that edge.
    task automatic send(input logic [2:0] op, input logic [CNT_W-1:0] data);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        cyc(1);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'd7;
        cmd_if.cmd_data  = '0;
    endtask

    initial begin
        rst              = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'd7;
        cmd_if.cmd_data  = '0;
        cyc(2);
        check("rst_out", out, 32'h0001);
        check("rst_running", running, 0);
        check("rst_step", step, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_if.cmd_ready, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", cmd_if.cmd_ready, 1);

        // Free-run rotate left, period 4
        send(OP_SET_PERIOD, 24'd4);
        send(OP_START, 24'd0);
        check("t1_start_out", out, 32'h0001);
        check("t1_running", running, 1);
        check("t1_start_step", step, 0);
        for (int i = 1; i <= 16; i++) begin
            cyc(3);
            check("t1_gap_step", step, 0);
            cyc(1);
            check("t1_out", out, 32'h1 << (i % 16));
            check("t1_step", step, 1);
        end
        check("t1_wrap", out, 32'h0001);
        send(OP_STOP, 24'd0);
        check("t1_stop_running", running, 0);

        // Rotate right, period 0 stored as 1, three steps
        send(OP_SET_PERIOD, 24'd0);
        send(OP_SET_MODE, 24'd1);
        send(OP_START, 24'd3);
        check("t2_start_out", out, 32'h0001);
        cyc(1);
        check("t2_out1", out, 32'h8000);
        check("t2_step1", step, 1);
        check("t2_done1", done, 0);
        cyc(1);
        check("t2_out2", out, 32'h4000);
        cyc(1);
        check("t2_out3", out, 32'h2000);
        check("t2_step3", step, 1);
        check("t2_done3", done, 1);
        check("t2_running3", running, 0);
        cyc(1);
        check("t2_hold_out", out, 32'h2000);
        check("t2_done_pulse", done, 0);
        check("t2_step_after", step, 0);

        // Bounce, period 1
        send(OP_LOAD, 24'h008000);
        send(OP_SET_MODE, 24'd2);
        send(OP_START, 24'd0);
        cyc(1);
        check("t3_flip_msb", out, 32'h4000);
        cyc(1);
        check("t3_next", out, 32'h2000);
        cyc(13);
        check("t3_reach_lsb", out, 32'h0001);
        cyc(1);
        check("t3_flip_lsb", out, 32'h0002);
        send(OP_STOP, 24'd0);
        check("t3_stop_hold", out, 32'h0002);
        check("t3_stop_step", step, 0);
        check("t3_stop_running", running, 0);

        // STOP colliding with a tick, period 3
        send(OP_SET_MODE, 24'd0);
        send(OP_SET_PERIOD, 24'd3);
        send(OP_LOAD, 24'h000001);
        send(OP_START, 24'd0);
        cyc(3);
        check("t4_first", out, 32'h0002);
        check("t4_first_step", step, 1);
        cyc(2);
        send(OP_STOP, 24'd0);
        check("t4_stop_out", out, 32'h0002);
        check("t4_stop_step", step, 0);
        check("t4_stop_running", running, 0);
        send(OP_START, 24'd2);
        cyc(3);
        check("t4_s1", out, 32'h0004);
        check("t4_s1_done", done, 0);
        cyc(3);
        check("t4_s2", out, 32'h0008);
        check("t4_s2_step", step, 1);
        check("t4_s2_done", done, 1);
        check("t4_s2_running", running, 0);
        cyc(1);
        check("t4_done_clear", done, 0);

        // LOAD colliding with a tick
        send(OP_START, 24'd0);
        cyc(2);
        send(OP_LOAD, 24'h0000F0);
        check("t5_load_out", out, 32'h00F0);
        check("t5_load_step", step, 0);
        check("t5_load_running", running, 1);
        cyc(2);
        check("t5_wait_out", out, 32'h00F0);
        check("t5_wait_step", step, 0);
        cyc(1);
        check("t5_shift", out, 32'h01E0);
        check("t5_shift_step", step, 1);

        // Reset mid-run
        send(OP_LOAD, 24'h000100);
        check("t6_pre_out", out, 32'h0100);
        rst = 1'b1;
        #1;
        check("t6_ready_in_rst", cmd_if.cmd_ready, 0);
        cyc(1);
        check("t6_rst_out", out, 32'h0001);
        check("t6_rst_running", running, 0);
        rst = 1'b0;
        send(OP_START, 24'd0);
        cyc(DEF_P - 1);
        check("t6_def_wait_out", out, 32'h0001);
        check("t6_def_wait_step", step, 0);
        cyc(1);
        check("t6_def_shift", out, 32'h0002);
        check("t6_def_step", step, 1);

        // Reserved op has no effect
        send(OP_STOP, 24'd0);
        send(3'd6, 24'h00ABCD);
        check("t7_noop_out", out, 32'h0002);
        check("t7_noop_running", running, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
